// File: rtl/tnn_neuron_scheduler_if.sv
// Operand-in / result-out stream bundle for the TNN neuron scheduler.
// slave = scheduler side, master = upstream/downstream side.
interface tnn_neuron_scheduler_if #(
    parameter int N_NEUR = 6,
    parameter int W      = 3,
    parameter int CW     = $clog2(N_NEUR + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic [W-1:0]      in_c;
    logic              out_valid;
    logic              out_ready;
    logic [N_NEUR-1:0] out_fire;
    logic [CW-1:0]     out_count;

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_fire, out_count
    );

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_fire, out_count
    );
endinterface

// File: rtl/tnn_neuron_scheduler.sv
// Buffers one operand triple per neuron, then sweeps them one per cycle through a
// shared external comparator and returns the fire vector with its popcount.
module tnn_neuron_scheduler #(
    parameter int N_NEUR = 6,
    parameter int W      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    tnn_neuron_scheduler_if.slave  bus,
    output logic                   cmp_en,
    output logic [W-1:0]           cmp_a,
    output logic [W-1:0]           cmp_b,
    output logic [W-1:0]           cmp_c,
    input  logic                   cmp_out
);
    localparam int CW = $clog2(N_NEUR + 1);
    localparam int IW = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_NEUR - 1);

    typedef enum logic [1:0] {LOAD = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_e;

    state_e                   state_q, state_d;
    logic [IW-1:0]            ld_idx_q, ld_idx_d;
    logic [IW-1:0]            ev_idx_q, ev_idx_d;
    logic [N_NEUR-1:0]        fire_q, fire_d;
    logic [CW-1:0]            count_q, count_d;
    logic [N_NEUR-1:0][W-1:0] a_q, b_q, c_q;
    logic                     in_xfer;

    assign in_xfer = bus.in_valid && (state_q == LOAD);

    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_xfer && ld_idx_q == LAST) state_d = EVAL;
            EVAL:    if (ev_idx_q == LAST)            state_d = DONE;
            DONE:    if (bus.out_ready)               state_d = LOAD;
            default:                                  state_d = LOAD;
        endcase
    end

    // Comparator operands come only from the registered buffer, so in_* activity
    // during EVAL cannot disturb them.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        cmp_en        = 1'b0;
        cmp_a         = '0;
        cmp_b         = '0;
        cmp_c         = '0;
        case (state_q)
            LOAD: bus.in_ready = 1'b1;
            EVAL: begin
                cmp_en = 1'b1;
                cmp_a  = a_q[ev_idx_q];
                cmp_b  = b_q[ev_idx_q];
                cmp_c  = c_q[ev_idx_q];
            end
            DONE: bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.out_fire  = fire_q;
    assign bus.out_count = count_q;

    always_comb begin
        ld_idx_d = ld_idx_q;
        ev_idx_d = ev_idx_q;
        fire_d   = fire_q;
        count_d  = count_q;
        if (in_xfer) begin
            if (ld_idx_q == LAST) begin
                ld_idx_d = '0;
                fire_d   = '0;
                count_d  = '0;
            end else begin
                ld_idx_d = ld_idx_q + IW'(1);
            end
        end
        if (state_q == EVAL) begin
            fire_d[ev_idx_q] = cmp_out;
            count_d          = count_q + CW'(cmp_out);
            ev_idx_d         = (ev_idx_q == LAST) ? '0 : ev_idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_idx_q <= '0;
            ev_idx_q <= '0;
            fire_q   <= '0;
            count_q  <= '0;
        end else begin
            ld_idx_q <= ld_idx_d;
            ev_idx_q <= ev_idx_d;
            fire_q   <= fire_d;
            count_q  <= count_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            a_q[ld_idx_q] <= bus.in_a;
            b_q[ld_idx_q] <= bus.in_b;
            c_q[ld_idx_q] <= bus.in_c;
        end
    end
endmodule

// File: tb/tb_tnn_neuron_scheduler.sv
// Scoreboard bench: a negedge monitor predicts every handshake and comparator
// cycle from the triples it sees accepted; the main process only drives stimulus.
module tb_tnn_neuron_scheduler;
    localparam int N  = 6;
    localparam int W  = 3;
    localparam int CW = $clog2(N + 1);

    typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] c; } trip_t;
    typedef struct packed { logic [N-1:0] fire; logic [CW-1:0] cnt; } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmp_en, cmp_out;
    logic [W-1:0] cmp_a, cmp_b, cmp_c;

    tnn_neuron_scheduler_if #(.N_NEUR(N), .W(W)) bus ();

    tnn_neuron_scheduler #(.N_NEUR(N), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .cmp_en (cmp_en),
        .cmp_a  (cmp_a),
        .cmp_b  (cmp_b),
        .cmp_c  (cmp_c),
        .cmp_out(cmp_out)
    );

    assign cmp_out = ({1'b0, cmp_a} + {1'b0, cmp_b}) > {1'b0, cmp_c};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    trip_t stim_q[$];
    trip_t pend[$];
    trip_t cur[$];
    res_t  exp_q[$];
    res_t  out_log[$];
    int    start_q[$];
    bit    busy = 0;
    bit    acc_seen = 0;
    bit    ov_prev = 0;
    int    ev_k = 0;
    int    en_cnt = 0;
    int    npass = 0;
    int    last_acc_cyc = 0;
    int    lat = -1;

    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            exp_q.delete();
            busy = 0; ev_k = 0; en_cnt = 0; acc_seen = 0; ov_prev = 0;
        end else begin
            chk("in_ready", 32'(bus.in_ready), 32'(!busy));
            chk("out_valid", 32'(bus.out_valid), 32'(busy && ev_k == N));
            chk("cmp_en", 32'(cmp_en), 32'(busy && ev_k < N));
            if (cmp_en) begin
                if (busy && ev_k < N) chk("cmp_operands", 32'({cmp_a, cmp_b, cmp_c}), 32'(cur[ev_k]));
                ev_k++;
                en_cnt++;
            end else begin
                chk("cmp_idle_zero", 32'({cmp_a, cmp_b, cmp_c}), 32'd0);
            end
            if (bus.out_valid && !ov_prev) lat = cyc - last_acc_cyc;
            ov_prev = bus.out_valid;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    chk("out_fire", 32'(bus.out_fire), 32'(exp_q[0].fire));
                    chk("out_count", 32'(bus.out_count), 32'(exp_q[0].cnt));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        chk("cmp_en_cycles", 32'(en_cnt), 32'(N));
                        out_log.push_back({bus.out_fire, bus.out_count});
                        busy = 0; ev_k = 0; en_cnt = 0;
                        npass++;
                    end
                end
            end
            acc_seen = bus.in_valid && bus.in_ready;
            if (acc_seen) begin
                pend.push_back({bus.in_a, bus.in_b, bus.in_c});
                if (pend.size() == 1) start_q.push_back(cyc + 1);
                if (pend.size() == N) begin
                    res_t r;
                    r = '0;
                    for (int k = 0; k < N; k++)
                        if (int'(pend[k].a) + int'(pend[k].b) > int'(pend[k].c)) begin
                            r.fire[k] = 1'b1;
                            r.cnt     = r.cnt + 1'b1;
                        end
                    exp_q.push_back(r);
                    cur = pend;
                    pend.delete();
                    busy = 1;
                    last_acc_cyc = cyc + 1;
                end
            end
        end
    end

    int vmode = 0;  // 0 always, 1 gapped in LOAD / held otherwise, 2 random
    int rmode = 0;  // 0 ready, 1 random, 2 stalled

    task automatic step();
        @(posedge clk);
        #2;
        if (acc_seen && stim_q.size() > 0) void'(stim_q.pop_front());
        case (vmode)
            0: bus.in_valid = stim_q.size() > 0;
            1: bus.in_valid = stim_q.size() > 0 && (!bus.in_ready || cyc % 3 == 0);
            default: bus.in_valid = stim_q.size() > 0 && ($urandom_range(0, 1) == 1);
        endcase
        if (bus.in_valid) {bus.in_a, bus.in_b, bus.in_c} = stim_q[0];
        else              {bus.in_a, bus.in_b, bus.in_c} = 9'($urandom);
        bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((stim_q.size() != 0 || busy || pend.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_cmp_en"},    32'(cmp_en), 32'd0);
        chk({tag, "_cmp_abc"},   32'({cmp_a, cmp_b, cmp_c}), 32'd0);
        chk({tag, "_out_fire"},  32'(bus.out_fire), 32'd0);
        chk({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(trip_t'(9'($urandom)));
    endtask

    initial begin
        int p0;
        int n;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset("reset");
        rst = 1'b0;

        // directed pass from known triples
        p0 = npass;
        stim_q.push_back({3'd1, 3'd1, 3'd1}); stim_q.push_back({3'd0, 3'd0, 3'd3});
        stim_q.push_back({3'd7, 3'd7, 3'd7}); stim_q.push_back({3'd3, 3'd4, 3'd7});
        stim_q.push_back({3'd2, 3'd2, 3'd5}); stim_q.push_back({3'd0, 3'd1, 3'd0});
        drain("t1", 100);
        chk("t1_passes", 32'(npass - p0), 32'd1);
        if (out_log.size() > 0) begin
            chk("t1_fire", 32'(out_log[$].fire), 32'h25);
            chk("t1_count", 32'(out_log[$].cnt), 32'd3);
        end
        chk("t1_latency", 32'(lat), 32'(N));

        // gapped in_valid during LOAD, held high through EVAL/DONE
        vmode = 1; p0 = npass;
        push_rand(2 * N);
        drain("t2", 300);
        chk("t2_passes", 32'(npass - p0), 32'd2);

        // output backpressure
        vmode = 0; rmode = 2;
        push_rand(N);
        n = 0;
        while (!bus.out_valid && n < 50) begin step(); n++; end
        chk("t3_reach_done", 32'(bus.out_valid), 32'd1);
        repeat (10) step();
        chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
        rmode = 0; step();
        rmode = 2; step();
        chk("t3_in_ready_after", 32'(bus.in_ready), 32'd1);
        chk("t3_out_valid_after", 32'(bus.out_valid), 32'd0);
        rmode = 0;

        // back-to-back all-fire / no-fire passes, period check
        start_q.delete(); p0 = npass;
        for (int i = 0; i < N; i++) stim_q.push_back({3'd7, 3'd7, 3'd0});
        for (int i = 0; i < N; i++) stim_q.push_back({3'd0, 3'd0, 3'd7});
        drain("t4", 100);
        chk("t4_passes", 32'(npass - p0), 32'd2);
        if (out_log.size() >= 2) begin
            chk("t4_fire_all", 32'(out_log[out_log.size()-2].fire), 32'h3f);
            chk("t4_count_all", 32'(out_log[out_log.size()-2].cnt), 32'd6);
            chk("t4_fire_none", 32'(out_log[$].fire), 32'h00);
            chk("t4_count_none", 32'(out_log[$].cnt), 32'd0);
        end
        if (start_q.size() == 2) chk("t4_period", 32'(start_q[1] - start_q[0]), 32'd13);
        else chk("t4_start_count", 32'(start_q.size()), 32'd2);

        // reset after 3 evaluations
        p0 = npass;
        push_rand(N);
        n = 0;
        while (ev_k < 3 && n < 50) begin step(); n++; end
        chk("t5a_reach_eval", 32'(ev_k), 32'd3);
        rst = 1'b1;
        @(posedge clk); #2;
        chk_reset("t5a");
        stim_q.delete(); bus.in_valid = 1'b0;
        rst = 1'b0;
        repeat (15) step();
        chk("t5a_no_out", 32'(npass - p0), 32'd0);

        // reset after 2 accepts, in_valid still high into the reset edge
        push_rand(N);
        n = 0;
        while (pend.size() < 2 && n < 50) begin step(); n++; end
        chk("t5b_reach_load", 32'(pend.size()), 32'd2);
        rst = 1'b1;
        @(posedge clk); #2;
        chk_reset("t5b");
        stim_q.delete(); bus.in_valid = 1'b0;
        rst = 1'b0;
        push_rand(N);
        drain("t5b", 100);
        chk("t5b_clean_pass", 32'(npass - p0), 32'd1);

        // random valid/ready traffic
        vmode = 2; rmode = 1; p0 = npass;
        push_rand(8 * N);
        drain("t6", 3000);
        chk("t6_passes", 32'(npass - p0), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
